fxp_mul_pipe: RTL and testbench
===============================

// Module: fxp_mul_pipe
// PURPOSE
//  Parametrised, pipelined signed fixed-point multiplier with valid/ready handshakes.
//  Takes operands in independent Qa/Qb formats and returns the product in a third Q format.
//  Output is rounded and saturated to that format, and overflow is flagged.
//  Sits between DSP datapath stages; back-pressure propagates upstream with no data loss.
// PARAMETERS
//  A_INT   6  integer bits of a, including sign
//  A_FRAC  8  fraction bits of a
//  B_INT   6  integer bits of b, including sign
//  B_FRAC  8  fraction bits of b
//  O_INT   8  integer bits of product, including sign; O_INT >= 1
//  O_FRAC  8  fraction bits of product; O_FRAC <= A_FRAC+B_FRAC, else elaboration error
// PORTS
//  clk         in   1                clock, rising edge
//  reset       in   1                asynchronous reset, active-low
//  in_valid    in   1                operand beat valid
//  in_ready    out  1                block can accept a beat
//  a           in   A_INT+A_FRAC     signed operand a
//  b           in   B_INT+B_FRAC     signed operand b
//  rnd_mode    in   1                0 = truncate (floor); 1 = round-half-up; travels with the beat
//  out_valid   out  1                product beat valid
//  out_ready   in   1                downstream accepts the beat
//  product     out  O_INT+O_FRAC     signed result
//  sat         out  1                this beat was saturated; qualified by out_valid
//  ovf_sticky  out  1                set by any saturated beat at transfer
//  clr_ovf     in   1                synchronous clear of ovf_sticky (and of ovf_count)
// BEHAVIOUR
//  - Reset (reset=0, async): all stage valids = 0; out_valid=0, product=0, sat=0, ovf_sticky=0.
//    in_ready is 1 from the first edge after reset deasserts.
//  - Transfers: input on in_valid&in_ready; output on out_valid&out_ready.
//  - Pipeline: 3 stages. S1 registers a, b, rnd_mode. S2 forms the full product
//    P = a*b (A_INT+A_FRAC+B_INT+B_FRAC bits, F = A_FRAC+B_FRAC fraction bits).
//    S3 rounds/saturates into the output register.
//  - Latency: beat accepted at edge N -> out_valid at edge N+3 if unstalled. Throughput 1/cycle.
//  - Stall: stage k advances when empty or stage k+1 advances. in_ready = !S1_valid | S1 advances.
//    Output regs hold product/sat stable while out_valid & !out_ready.
//    Up to 3 beats are buffered; order is preserved and nothing is dropped or duplicated.
//  - Rounding: sh = F - O_FRAC. If rnd_mode=1 and sh>0, add 2^(sh-1) to P at full+1 width,
//    then arithmetic shift right by sh. sh=0 -> no rounding.
//  - Saturation: if the result is > max of Q(O_INT.O_FRAC), output 0111..1; if < min,
//    output 1000..0; sat=1. Otherwise the low bits pass through and sat=0.
//  - ovf_sticky: set on the edge of a transfer with sat=1; cleared by clr_ovf.
//    clr_ovf has priority over a simultaneous set.
//  - Reset mid-operation: all in-flight beats are discarded; no partial output appears.
// CONFIGURATION
//  FXP_MUL_OVF_CNT_EN defined:
//    - Adds output ovf_count [15:0]: count of transferred saturated beats.
//    - Saturates at 16'hFFFF; reset value 0; cleared by clr_ovf.
//  Undefined: no ovf_count port and no counter logic; all else identical.
// TESTING (default params: Q6.8 x Q6.8 -> Q8.8)
//  1. a=0x0180 (1.5), b=0x0240 (2.25), rnd=0, out_ready=1
//     -> product=0x0360 (3.375), sat=0, exactly 3 cycles after accept.
//  2. a=0x0001, b=0x0080, rnd=0 -> 0x0000; rnd=1 -> 0x0001.
//     a=0x3FFF (-1/256), b=0x0080: rnd=0 -> 0xFFFF; rnd=1 -> 0x0000.
//  3. a=0x1F00 (31), b=0x1F00 -> product=0x7FFF, sat=1, ovf_sticky=1.
//     a=0x2000 (-32), b=0x1F00 -> 0x8000, sat=1. Pulse clr_ovf -> ovf_sticky=0.
//  4. Stream 8 beats (a=1..8, b=0x0100) with out_ready low cycles 4-8
//     -> in_ready=0 once 3 beats are held; outputs 1..8 in order; product stable while stalled.
//  5. Assert reset low with 2 beats in flight
//     -> out_valid=0 immediately; after release, no stale beat emerges; next beat has 3-cycle latency.
//  6. With FXP_MUL_OVF_CNT_EN: 3 saturating beats -> ovf_count=3; clr_ovf -> 0.
//     Without the macro: elaborates with no ovf_count port.

Source files
------------

// File: rtl/fxp_mul_pipe.sv
// fxp_mul_pipe
//   Pipelined signed fixed-point multiplier with valid/ready handshakes.
//   The operands a (Q A_INT.A_FRAC) and b (Q B_INT.B_FRAC) are multiplied
//   at full precision. The product is then rounded (floor or round-half-up,
//   chosen per beat) and saturated into Q O_INT.O_FRAC.
//   There are three register stages: operand capture, full product, and
//   round/saturate into the output register. Back-pressure stalls the
//   pipeline without losing or duplicating beats.
//
// Ports
//   clk        rising-edge clock
//   reset      asynchronous reset, active low
//   in_valid   operand beat valid          in_ready   block can accept a beat
//   a, b       signed operands             rnd_mode   0 floor, 1 round-half-up
//   out_valid  product beat valid          out_ready  downstream accepts beat
//   product    signed result               sat        beat was saturated
//   ovf_sticky set by any saturated beat at transfer
//   clr_ovf    synchronous clear of ovf_sticky (and ovf_count)
//
// Configuration
//   FXP_MUL_OVF_CNT_EN  adds ovf_count[15:0]. It counts transferred saturated
//                       beats and holds at 16'hFFFF.
module fxp_mul_pipe #(
   parameter int A_INT  = 6,
   parameter int A_FRAC = 8,
   parameter int B_INT  = 6,
   parameter int B_FRAC = 8,
   parameter int O_INT  = 8,
   parameter int O_FRAC = 8
) (
   input  logic                            clk,
   input  logic                            reset,
   input  logic                            in_valid,
   output logic                            in_ready,
   input  logic signed [A_INT+A_FRAC-1:0]  a,
   input  logic signed [B_INT+B_FRAC-1:0]  b,
   input  logic                            rnd_mode,
   output logic                            out_valid,
   input  logic                            out_ready,
   output logic signed [O_INT+O_FRAC-1:0]  product,
   output logic                            sat,
   output logic                            ovf_sticky,
   input  logic                            clr_ovf
`ifdef FXP_MUL_OVF_CNT_EN
   ,
   output logic [15:0]                     ovf_count
`endif
);

   localparam int AW = A_INT + A_FRAC;
   localparam int BW = B_INT + B_FRAC;
   localparam int OW = O_INT + O_FRAC;
   localparam int PW = AW + BW;
   localparam int F  = A_FRAC + B_FRAC;
   localparam int SH = F - O_FRAC;
   // Headroom wide enough that the rounding add and the range test never wrap.
   localparam int XW = PW + OW + 1;

   if (O_FRAC > F || O_INT < 1) begin : g_param_check
      $error("fxp_mul_pipe: need O_FRAC <= A_FRAC+B_FRAC and O_INT >= 1");
   end

   function automatic logic [XW-1:0] half_lsb();
      logic [XW-1:0] r;
      r = '0;
      for (int unsigned i = 0; i < XW; i++)
         if (i + 1 == SH) r[i] = 1'b1;
      return r;
   endfunction

   localparam logic [XW-1:0] HALF = half_lsb();

   // Pipeline state
   logic                  ready_en;
   logic                  s1_v, s2_v;
   logic signed [AW-1:0]  s1_a;
   logic signed [BW-1:0]  s1_b;
   logic                  s1_rnd, s2_rnd;
   logic signed [PW-1:0]  s2_p;

   logic s3_adv, s2_adv;

   // A stage may load when it is empty or when its contents move on.
   assign s3_adv   = !out_valid | out_ready;
   assign s2_adv   = !s2_v | s3_adv;
   assign in_ready = ready_en & (!s1_v | s2_adv);

   // ready_en holds in_ready low until the first edge after reset is released.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) ready_en <= 1'b0;
      else        ready_en <= 1'b1;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         s1_v   <= 1'b0;
         s1_a   <= '0;
         s1_b   <= '0;
         s1_rnd <= 1'b0;
      end else if (in_ready) begin
         s1_v <= in_valid;
         if (in_valid) begin
            s1_a   <= a;
            s1_b   <= b;
            s1_rnd <= rnd_mode;
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         s2_v   <= 1'b0;
         s2_p   <= '0;
         s2_rnd <= 1'b0;
      end else if (s2_adv) begin
         s2_v <= s1_v;
         if (s1_v) begin
            s2_p   <= s1_a * s1_b;
            s2_rnd <= s1_rnd;
         end
      end
   end

   // Round and saturate
   logic signed [XW-1:0] p_ext, p_rnd, p_shr;
   logic [XW-OW:0]       p_hi;
   logic                 ovf_pos, ovf_neg;
   logic [OW-1:0]        res_q;

   always_comb begin
      p_ext   = {{(XW-PW){s2_p[PW-1]}}, s2_p};
      p_rnd   = p_ext + (s2_rnd ? HALF : '0);
      p_shr   = p_rnd >>> SH;
      // Result fits only if every bit from the output sign bit upward agrees.
      p_hi    = p_shr[XW-1:OW-1];
      ovf_pos = !p_shr[XW-1] && (|p_hi);
      ovf_neg =  p_shr[XW-1] && !(&p_hi);
      res_q   = p_shr[OW-1:0];
      if (ovf_pos)      res_q = {1'b0, {(OW-1){1'b1}}};
      else if (ovf_neg) res_q = {1'b1, {(OW-1){1'b0}}};
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         out_valid <= 1'b0;
         product   <= '0;
         sat       <= 1'b0;
      end else if (s3_adv) begin
         out_valid <= s2_v;
         if (s2_v) begin
            product <= res_q;
            sat     <= ovf_pos | ovf_neg;
         end
      end
   end

   logic sat_xfer;
   assign sat_xfer = out_valid & out_ready & sat;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)        ovf_sticky <= 1'b0;
      else if (clr_ovf)  ovf_sticky <= 1'b0;
      else if (sat_xfer) ovf_sticky <= 1'b1;
   end

`ifdef FXP_MUL_OVF_CNT_EN
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)                             ovf_count <= '0;
      else if (clr_ovf)                       ovf_count <= '0;
      else if (sat_xfer && ovf_count != '1)   ovf_count <= ovf_count + 16'd1;
   end
`endif

endmodule

// File: tb/tb_fxp_mul_pipe.sv
// Scoreboard bench for fxp_mul_pipe at default parameters (Q6.8 x Q6.8 -> Q8.8).
module tb_fxp_mul_pipe;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [13:0] a = '0;
   logic [13:0] b = '0;
   logic        rnd_mode = 1'b0;
   logic        out_valid;
   logic        out_ready = 1'b1;
   logic [15:0] product;
   logic        sat;
   logic        ovf_sticky;
   logic        clr_ovf = 1'b0;
`ifdef FXP_MUL_OVF_CNT_EN
   logic [15:0] ovf_count;
`endif

   fxp_mul_pipe #(
      .A_INT(6), .A_FRAC(8), .B_INT(6), .B_FRAC(8), .O_INT(8), .O_FRAC(8)
   ) dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .rnd_mode(rnd_mode), .out_valid(out_valid),
      .out_ready(out_ready), .product(product), .sat(sat),
      .ovf_sticky(ovf_sticky), .clr_ovf(clr_ovf)
`ifdef FXP_MUL_OVF_CNT_EN
      , .ovf_count(ovf_count)
`endif
   );

   always #5 clk = ~clk;

   typedef struct { logic [15:0] p; logic s; } exp_t;
   exp_t q[$];
   int   n_cmp  = 0;
   int   n_fail = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Monitor: every presented beat must match the head of the scoreboard.
   // A stalled beat is checked every cycle, so it must stay stable.
   always begin
      @(negedge clk);
      #2;
      if (reset && out_valid) begin
         if (q.size() == 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL spurious_beat: got product 0x%0h, expected no beat", product);
         end else begin
            chk("product", product, q[0].p);
            chk("sat", sat, q[0].s);
            if (out_ready) void'(q.pop_front());
         end
      end
   end

   // Present one beat, push its expectation on handshake, then drop in_valid.
   // With lat set, also measure the cycles from handshake to out_valid.
   task automatic send(input logic [13:0] av, input logic [13:0] bv, input logic r,
                       input logic [15:0] ep, input logic es, input bit lat);
      bit got;
      int k;
      got = 1'b0;
      k   = 0;
      @(negedge clk);
      a = av; b = bv; rnd_mode = r; in_valid = 1'b1;
      for (int i = 0; i < 50 && !got; i++) begin
         #1;
         if (in_ready) begin
            q.push_back('{p: ep, s: es});
            got = 1'b1;
         end else begin
            @(negedge clk);
         end
      end
      if (!got) begin
         n_cmp++;
         n_fail++;
         $display("FAIL handshake_timeout: in_ready stayed 0, expected 1");
         in_valid = 1'b0;
         return;
      end
      for (int i = 1; i <= 8; i++) begin
         @(negedge clk);
         if (i == 1) in_valid = 1'b0;
         #1;
         if (lat && out_valid && k == 0) k = i;
         if (!lat || k != 0) break;
      end
      if (lat) chk("latency", k, 3);
   endtask

   task automatic drain();
      for (int i = 0; i < 40 && (q.size() != 0 || out_valid); i++) @(negedge clk);
      #3;
      chk("drain_left", q.size(), 0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      bit saw_block;
      int idx;

      // Reset state
      repeat (2) @(negedge clk);
      #1;
      chk("rst_out_valid", out_valid, 0);
      chk("rst_product", product, 16'h0000);
      chk("rst_sat", sat, 0);
      chk("rst_ovf_sticky", ovf_sticky, 0);
      chk("rst_in_ready", in_ready, 0);
      @(negedge clk);
      reset = 1'b1;
      #1;
      chk("in_ready_before_edge", in_ready, 0);
      @(negedge clk);
      #1;
      chk("in_ready_after_edge", in_ready, 1);

      // 1.5 * 2.25 = 3.375, with a latency of 3 cycles
      send(14'h0180, 14'h0240, 1'b0, 16'h0360, 1'b0, 1'b1);
      drain();

      // Rounding around half an LSB, for both signs
      send(14'h0001, 14'h0080, 1'b0, 16'h0000, 1'b0, 1'b0);
      send(14'h0001, 14'h0080, 1'b1, 16'h0001, 1'b0, 1'b0);
      send(14'h3FFF, 14'h0080, 1'b0, 16'hFFFF, 1'b0, 1'b0);
      send(14'h3FFF, 14'h0080, 1'b1, 16'h0000, 1'b0, 1'b0);
      // Range edges that still fit: (-1)*(-1), -32*4 = min exactly, 31.996*4
      send(14'h3F00, 14'h3F00, 1'b0, 16'h0100, 1'b0, 1'b0);
      send(14'h2000, 14'h0400, 1'b0, 16'h8000, 1'b0, 1'b0);
      send(14'h1FFF, 14'h0400, 1'b1, 16'h7FFC, 1'b0, 1'b0);
      drain();
      chk("ovf_sticky_clean", ovf_sticky, 0);

      // Saturation in both directions
      send(14'h1F00, 14'h1F00, 1'b0, 16'h7FFF, 1'b1, 1'b0);
      send(14'h2000, 14'h1F00, 1'b0, 16'h8000, 1'b1, 1'b0);
      drain();
      chk("ovf_sticky_set", ovf_sticky, 1);
`ifdef FXP_MUL_OVF_CNT_EN
      send(14'h1F00, 14'h1F00, 1'b1, 16'h7FFF, 1'b1, 1'b0);
      drain();
      chk("ovf_count_3", ovf_count, 3);
`endif
      @(negedge clk);
      clr_ovf = 1'b1;
      @(negedge clk);
      clr_ovf = 1'b0;
      #1;
      chk("ovf_sticky_clr", ovf_sticky, 0);
`ifdef FXP_MUL_OVF_CNT_EN
      chk("ovf_count_clr", ovf_count, 0);
`endif

      // Stream 8 beats, with out_ready low on stream cycles 4..8
      saw_block = 1'b0;
      idx = 0;
      for (int cyc = 1; cyc <= 60 && idx < 8; cyc++) begin
         @(negedge clk);
         out_ready = !(cyc >= 4 && cyc <= 8);
         in_valid  = 1'b1;
         a         = 14'(idx + 1);
         b         = 14'h0100;
         rnd_mode  = 1'b0;
         #1;
         if (in_ready) begin
            q.push_back('{p: 16'(idx + 1), s: 1'b0});
            idx++;
         end else begin
            saw_block = 1'b1;
         end
      end
      @(negedge clk);
      in_valid  = 1'b0;
      out_ready = 1'b1;
      chk("stream_accepted", idx, 8);
      chk("in_ready_blocked", saw_block, 1);
      drain();

      // Reset with beats in flight: one at the output, one in S2
      @(negedge clk);
      a = 14'h0100; b = 14'h0100; rnd_mode = 1'b0; in_valid = 1'b1;
      #1;
      chk("flight_ready1", in_ready, 1);
      q.push_back('{p: 16'h0100, s: 1'b0});
      @(negedge clk);
      a = 14'h0200;
      #1;
      chk("flight_ready2", in_ready, 1);
      q.push_back('{p: 16'h0200, s: 1'b0});
      @(negedge clk);
      in_valid = 1'b0;
      @(negedge clk);
      reset = 1'b0;
      q.delete();
      #1;
      chk("midrst_out_valid", out_valid, 0);
      chk("midrst_product", product, 16'h0000);
      chk("midrst_in_ready", in_ready, 0);
      repeat (2) @(negedge clk);
      reset = 1'b1;
      repeat (6) @(negedge clk);
      #3;
      chk("no_stale_beat", out_valid, 0);
      send(14'h0300, 14'h3E00, 1'b0, 16'hFA00, 1'b0, 1'b1);
      drain();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
